// File: rtl/dms_pkg.sv
// Shared types and width helpers for the CDR charge-pump loop controller.
package dms_pkg;

  // Loop state; encoding is visible on the state output port.
  typedef enum logic [1:0] {
    CP_IDLE = 2'd0,
    CP_ACQ  = 2'd1,
    CP_TRK  = 2'd2,
    CP_LOCK = 2'd3
  } cp_state_t;

  // Signed net vote width: holds +/-vote_w with one bit of headroom.
  function automatic int net_width(input int vote_w);
    return $clog2(vote_w) + 2;
  endfunction

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold 0..n inclusive.
  function automatic int sat_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dms_cp_pulse.sv
// Charge-pump pulse generator: one registered up or down pulse of a
// programmable width, timed by a down-counter and killed by abort.
module dms_cp_pulse
  import dms_pkg::*;
#(
  parameter int WIDTH_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               start_up,
  input  logic               start_dn,
  input  logic [WIDTH_W-1:0] width,
  output logic               up,
  output logic               down
);

  logic [WIDTH_W-1:0] cnt;
  logic               start;

  // Up wins if both starts ever coincide, so up and down stay exclusive.
  assign start = (start_up | start_dn) & (width != '0);

  // Load the remaining-cycle count on start, count down, drop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up   <= 1'b0;
      down <= 1'b0;
      cnt  <= '0;
    end else if (abort) begin
      up   <= 1'b0;
      down <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      up   <= start_up;
      down <= start_dn & ~start_up;
      cnt  <= width - WIDTH_W'(1);
    end else if (cnt != '0) begin
      cnt  <= cnt - WIDTH_W'(1);
    end else begin
      up   <= 1'b0;
      down <= 1'b0;
    end
  end

endmodule

// File: rtl/dms_cp_ctrl.sv
// Bang-bang CDR loop controller. Accumulates early/late votes over fixed
// windows, fires one charge-pump pulse per window and tracks lock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CP_IDLE | loop disabled, counters cleared, no pulses
//   CP_ACQ  | acquiring: wide pulses, waiting for a balanced window
//   CP_TRK  | tracking: narrow pulses, counting consecutive balanced wins
//   CP_LOCK | locked: narrow pulses, leaves only on a bad window
module dms_cp_ctrl
  import dms_pkg::*;
#(
  parameter int VOTE_W     = 16,
  parameter int PW_ACQ     = 8,
  parameter int PW_TRK     = 2,
  parameter int LOCK_THR   = 2,
  parameter int UNLOCK_THR = 8,
  parameter int LOCK_CNT   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         vld,
  input  logic                         early,
  input  logic                         late,
  output logic                         up,
  output logic                         down,
  output logic                         locked,
  output logic [1:0]                   state,
  output logic [net_width(VOTE_W)-1:0] net_last
);

  localparam int NW  = net_width(VOTE_W);
  localparam int CW  = cnt_width(VOTE_W);
  localparam int LW  = sat_width(LOCK_CNT);
  localparam int PWW = CW;

  cp_state_t             st_q, st_d;
  logic [CW-1:0]         smp_q;
  logic signed [NW-1:0]  net_q;
  logic signed [NW-1:0]  net_nxt;
  logic signed [NW-1:0]  delta;
  logic signed [NW-1:0]  net_last_q;
  logic [LW-1:0]         lck_q, lck_d;
  logic                  take;
  logic                  win_end;
  logic                  balanced;
  logic                  bad;
  logic                  start_up;
  logic                  start_dn;
  logic [PWW-1:0]        pw_sel;
  int                    net_i;
  int                    net_abs;

  // A sample counts only while enabled and out of IDLE.
  assign take    = en & vld & (st_q != CP_IDLE);
  assign win_end = take & (smp_q == CW'(VOTE_W - 1));

  // Per-sample vote: late pushes up, early pushes down, ties count as zero.
  always_comb begin
    delta = '0;
    if (late && !early) begin
      delta = {{(NW-1){1'b0}}, 1'b1};
    end else if (early && !late) begin
      delta = '1;
    end
  end

  assign net_nxt = take ? (net_q + delta) : net_q;

  // Window classification on the final net including the closing sample.
  always_comb begin
    net_i    = int'(net_nxt);
    net_abs  = (net_i < 0) ? -net_i : net_i;
    balanced = (net_abs <= LOCK_THR);
    bad      = (net_abs >= UNLOCK_THR);
  end

  // Vote accumulator and sample counter; cleared at window end or disable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      net_q <= '0;
    end else if (!en || win_end) begin
      smp_q <= '0;
      net_q <= '0;
    end else if (take) begin
      smp_q <= smp_q + CW'(1);
      net_q <= net_nxt;
    end
  end

  // Last completed window's net vote; survives disable, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_last_q <= '0;
    end else if (win_end) begin
      net_last_q <= net_nxt;
    end
  end

  // State and lock-run counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= CP_IDLE;
      lck_q <= '0;
    end else begin
      st_q  <= st_d;
      lck_q <= lck_d;
    end
  end

  // Next-state logic; transitions other than enable happen at window end.
  always_comb begin
    st_d  = st_q;
    lck_d = lck_q;
    if (!en) begin
      st_d  = CP_IDLE;
      lck_d = '0;
    end else begin
      case (st_q)
        CP_IDLE: begin
          st_d = CP_ACQ;
        end
        CP_ACQ: begin
          if (win_end && balanced) begin
            st_d  = CP_TRK;
            lck_d = '0;
          end
        end
        CP_TRK: begin
          if (win_end) begin
            if (bad) begin
              st_d  = CP_ACQ;
              lck_d = '0;
            end else if (balanced) begin
              if (lck_q != LW'(LOCK_CNT)) begin
                lck_d = lck_q + LW'(1);
              end
              if (lck_q >= LW'(LOCK_CNT - 1)) begin
                st_d = CP_LOCK;
              end
            end else begin
              lck_d = '0;
            end
          end
        end
        CP_LOCK: begin
          if (win_end && bad) begin
            st_d  = CP_ACQ;
            lck_d = '0;
          end
        end
        default: begin
          st_d  = CP_IDLE;
          lck_d = '0;
        end
      endcase
    end
  end

  // Pulse direction from the sign of the final net; width from the state
  // the loop was in when the window closed.
  assign start_up = win_end & ~net_nxt[NW-1] & (net_nxt != '0);
  assign start_dn = win_end &  net_nxt[NW-1];
  assign pw_sel   = (st_q == CP_ACQ) ? PWW'(PW_ACQ) : PWW'(PW_TRK);

  dms_cp_pulse #(
    .WIDTH_W (PWW)
  ) u_pulse (
    .clk      (clk),
    .rst_n    (rst_n),
    .abort    (~en),
    .start_up (start_up),
    .start_dn (start_dn),
    .width    (pw_sel),
    .up       (up),
    .down     (down)
  );

  assign state    = st_q;
  assign locked   = (st_q == CP_LOCK);
  assign net_last = net_last_q;

endmodule

// File: tb/tb_dms_cp_ctrl.sv
// Directed bench for dms_cp_ctrl. Stimulus pushes the expected outcome of
// each vote window into a queue; a monitor pops it when the window closes
// and checks net_last, state, locked and the resulting pulse.
module tb_dms_cp_ctrl;
  import dms_pkg::*;

  localparam int VOTE_W = 16;
  localparam int PW_ACQ = 8;
  localparam int PW_TRK = 2;
  localparam int NW     = $clog2(VOTE_W) + 2;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en    = 1'b0;
  logic                 vld   = 1'b0;
  logic                 early = 1'b0;
  logic                 late  = 1'b0;
  logic                 up;
  logic                 down;
  logic                 locked;
  logic [1:0]           state;
  logic signed [NW-1:0] net_last;

  logic win_strobe = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  typedef struct {
    int net;
    int st;
    int upw;
    int dnw;
  } exp_t;

  exp_t exp_q[$];

  dms_cp_ctrl #(
    .VOTE_W     (VOTE_W),
    .PW_ACQ     (PW_ACQ),
    .PW_TRK     (PW_TRK),
    .LOCK_THR   (2),
    .UNLOCK_THR (8),
    .LOCK_CNT   (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .vld      (vld),
    .early    (early),
    .late     (late),
    .up       (up),
    .down     (down),
    .locked   (locked),
    .state    (state),
    .net_last (net_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic e, input logic last);
    @(negedge clk);
    vld        = v;
    late       = l;
    early      = e;
    win_strobe = last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // nl late-only, ne early-only, nb both samples; gap idle cycles between
  // samples; exp_st is the state after the window; exp_pw the pulse width.
  task automatic window(input int nl, input int ne, input int nb, input int gap,
                        input int exp_st, input int exp_pw);
    exp_t e;
    int   tot;
    tot   = nl + ne + nb;
    e.net = nl - ne;
    e.st  = exp_st;
    e.upw = (nl > ne) ? exp_pw : 0;
    e.dnw = (ne > nl) ? exp_pw : 0;
    exp_q.push_back(e);
    for (int i = 0; i < tot; i++) begin
      if (gap > 0 && i > 0) idle(gap);
      if (i < nl)           drive(1'b1, 1'b1, 1'b0, i == tot - 1);
      else if (i < nl + ne) drive(1'b1, 1'b0, 1'b1, i == tot - 1);
      else                  drive(1'b1, 1'b1, 1'b1, i == tot - 1);
    end
  endtask

  // Balanced window patterns with |net| <= 2.
  task automatic bal(input int k, input int exp_st);
    case (k % 4)
      0:       window(9, 7, 0, 0, exp_st, PW_TRK);
      1:       window(7, 9, 0, 0, exp_st, PW_TRK);
      2:       window(6, 6, 4, 0, exp_st, PW_TRK);
      default: window(8, 7, 1, 0, exp_st, PW_TRK);
    endcase
  endtask

  // Monitor: a window closes on the posedge where win_strobe is high.
  initial begin : monitor
    exp_t e;
    int   uc, dc, ov;
    forever begin
      @(posedge clk);
      if (win_strobe) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL scoreboard_underflow: window closed with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("net_last", int'(net_last), e.net);
          check("state", int'(state), e.st);
          check("locked", int'(locked), (e.st == 3) ? 1 : 0);
          check("pulse_first_up", int'(up), (e.upw > 0) ? 1 : 0);
          check("pulse_first_dn", int'(down), (e.dnw > 0) ? 1 : 0);
          uc = 0;
          dc = 0;
          ov = 0;
          for (int i = 0; i < PW_ACQ + 2; i++) begin
            if (i > 0) @(negedge clk);
            uc += int'(up);
            dc += int'(down);
            ov += int'(up & down);
          end
          check("up_width", uc, e.upw);
          check("down_width", dc, e.dnw);
          check("up_down_overlap", ov, 0);
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_up", int'(up), 0);
    check("rst_down", int'(down), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_net_last", int'(net_last), 0);

    rst_n = 1'b1;
    check("idle_at_release", int'(state), 0);
    @(negedge clk);
    check("acq_after_enable", int'(state), 1);

    // Acquire pulse, then abort 3 cycles into the 8-cycle up pulse while
    // two more samples land in a partial window that must be discarded.
    window(16, 0, 0, 0, 1, 3);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    en = 1'b0; vld = 1'b0; late = 1'b0; early = 1'b0; win_strobe = 1'b0;
    @(negedge clk);
    check("abort_state_idle", int'(state), 0);
    check("abort_up_low", int'(up), 0);
    check("abort_net_last_hold", int'(net_last), 16);
    en = 1'b1;
    @(negedge clk);
    check("reenable_acq", int'(state), 1);

    // Fresh window after re-enable: full 16 early samples.
    window(0, 16, 0, 0, 1, PW_ACQ);
    // Balanced (+2) in ACQ: to TRACK, pulse still ACQ width.
    window(9, 7, 0, 0, 2, PW_ACQ);
    for (int k = 0; k < 5; k++) bal(k, 2);
    // Neither balanced nor bad: lock run restarts.
    window(10, 5, 1, 0, 2, PW_TRK);
    for (int k = 0; k < 32; k++) bal(k, (k == 31) ? 3 : 2);
    // Stay in LOCK on balanced and on in-between windows.
    window(5, 5, 6, 0, 3, PW_TRK);
    window(11, 5, 0, 0, 3, PW_TRK);
    // Bad window (-8) from LOCK: back to ACQ, narrow down pulse.
    window(4, 12, 0, 0, 1, PW_TRK);
    // Ties only, with vld gaps: net 0, no pulse, balanced so ACQ->TRACK.
    window(0, 0, 16, 1, 2, PW_ACQ);
    // Gapped in-between window (+4) in TRACK.
    window(10, 6, 0, 2, 2, PW_TRK);
    // Bad window from TRACK.
    window(16, 0, 0, 0, 1, PW_TRK);
    // Reset asserted 2 cycles into an 8-cycle acquire pulse.
    window(16, 0, 0, 0, 1, 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_up", int'(up), 0);
    check("async_rst_down", int'(down), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_net_last", int'(net_last), 0);

    repeat (12) @(negedge clk);
    rst_n = 1'b1;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dms_cp_ctrl.md
Name: dms_cp_ctrl

Overview:
Bang-bang CDR loop controller that sequences the charge pump. Collects early/late phase decisions from the sampler over fixed vote windows. At the end of each window it issues one registered up or down pulse, whose width depends on the loop state. Sits between the phase-decision logic and the charge pump's up/down inputs, and also tracks acquisition/lock state for the rest of the CDR.

Parameters:
VOTE_W, 16, number of valid decisions per vote window (>=4)
PW_ACQ, 8, up/down pulse width in clk cycles in ACQ state (must be < VOTE_W)
PW_TRK, 2, pulse width in TRACK and LOCK states (1..PW_ACQ)
LOCK_THR, 2, window is "balanced" when |net| <= LOCK_THR
UNLOCK_THR, 8, window is "bad" when |net| >= UNLOCK_THR (> LOCK_THR)
LOCK_CNT, 32, consecutive balanced windows needed in TRACK to declare lock

Ports:
clk  input  1  loop controller clock
rst_n  input  1  asynchronous active-low reset
en  input  1  loop enable; low forces IDLE
vld  input  1  early/late valid this cycle
early  input  1  data edge early -> needs down
late  input  1  data edge late -> needs up
up  output  1  charge-pump up drive (registered)
down  output  1  charge-pump down drive (registered)
locked  output  1  high in LOCK state
state  output  2  IDLE=0, ACQ=1, TRACK=2, LOCK=3
net_last  output  $clog2(VOTE_W)+2  signed net vote of last completed window

Behaviour:
- Reset (async, rst_n low): state=IDLE; up=0, down=0, locked=0, net_last=0; all counters cleared. Outputs remain 0 until rst_n deasserts and a window completes.
- Voting: each cycle with vld=1 and state!=IDLE counts as one window sample.
  - late&!early: net += 1.
  - early&!late: net -= 1.
  - both or neither: net unchanged, but the sample still counts.
  - net is signed, $clog2(VOTE_W)+2 bits, and cannot overflow.
- Window end: the cycle the VOTE_W-th sample is taken.
  - net_last <= final net, including that sample.
  - The accumulator and sample counter restart at 0 the next cycle.
- Pulse: starts the cycle after window end and is never concurrent with the other pulse.
  - net>0: up=1 for PW cycles.
  - net<0: down=1 for PW cycles.
  - net=0: no pulse.
  - PW = PW_ACQ if the state at window end is ACQ, otherwise PW_TRK.
  - Because PW < VOTE_W, a pulse always ends before the next window end. Voting continues during pulses.
- FSM, evaluated at window end (except en):
  - IDLE -> ACQ the cycle after en=1.
  - ACQ -> TRACK if the window is balanced; lock counter cleared.
  - TRACK: a balanced window increments the lock counter (saturating). On reaching LOCK_CNT -> LOCK.
  - TRACK: a bad window -> ACQ, lock counter cleared.
  - TRACK: a neither-balanced-nor-bad window clears the lock counter and stays in TRACK.
  - LOCK -> ACQ on a bad window. Otherwise stay in LOCK.
  - locked = (state==LOCK), registered with state.
- en=0 in any state:
  - Next cycle: state=IDLE; up/down=0, even mid-pulse; locked=0; vote and lock counters cleared.
  - net_last holds its value.
  - Re-enable restarts at ACQ with a fresh window.
- rst_n asserted mid-pulse or mid-window: outputs drop asynchronously to 0. No partial window survives.
- Invariant: up&down never both 1.

Decomposition:
- Shared package dms_pkg holds:
  - typedef enum logic [1:0] {CP_IDLE, CP_ACQ, CP_TRK, CP_LOCK} cp_state_t
  - localparam-width helper for the net vote width
- One natural sub-module: dms_cp_pulse, a pulse generator.
  - Inputs: start_up, start_dn, width.
  - Outputs: up, down.
  - Contains a down-counter and clears on an abort input driven by !en.

Test Plan:
- Reset/enable: hold rst_n=0, then release with en=1 -> state goes IDLE then ACQ one cycle later; up=down=locked=0 throughout the first window.
- Acquire pulse: 16 vld cycles all late=1 -> net_last=+16; up high exactly 8 cycles starting the cycle after window end; down stays 0; state stays ACQ.
- Balanced window: mix of 9 late and 7 early -> net_last=+2; state ACQ->TRACK; up pulse 2 cycles wide in subsequent windows.
- Lock: after TRACK, 32 consecutive windows with |net|<=2 -> locked=1 on the cycle after the 32nd window end. Then one window of 12 early / 4 late (net=-8) -> state ACQ, locked=0, down pulse 2 cycles (state was LOCK at window end).
- Abort: drop en 3 cycles into an 8-cycle up pulse -> up=0 next cycle, state=IDLE; re-enable gives a fresh 16-sample window.
- Corner: early=late=1 on all 16 samples -> net_last=0, no pulse, window still completes; vld gaps stretch the window without changing net.
